// File: rtl/cstn_pkg.sv
// Shared types and derived timing for the CSTN/STN panel timing controller.
package cstn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int unsigned h_total(input int unsigned h_front, input int unsigned h_act,
                                            input int unsigned h_back, input int unsigned h_lp,
                                            input int unsigned h_wait);
        return h_front + h_act + h_back + h_lp + h_wait;
    endfunction

    function automatic int unsigned lines(input int unsigned v_act, input int unsigned v_back,
                                          input int unsigned dual_scan);
        return v_act / (1 + dual_scan) + v_back;
    endfunction

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned bus_w);
        return word_w / bus_w;
    endfunction

    function automatic bit params_ok(input int unsigned bus_w, input int unsigned word_w,
                                     input int unsigned dual_scan, input int unsigned h_act,
                                     input int unsigned h_lp, input int unsigned v_act);
        bit ok;
        ok = 1'b1;
        if (bus_w != 4 && bus_w != 8) ok = 1'b0;
        if (word_w < bus_w || (word_w % bus_w) != 0) ok = 1'b0;
        if (dual_scan > 1) ok = 1'b0;
        if (h_act == 0 || h_lp == 0 || v_act == 0) ok = 1'b0;
        if (bus_w != 0 && word_w >= bus_w && (h_act % (word_w / bus_w)) != 0) ok = 1'b0;
        if (dual_scan == 1 && (v_act % 2) != 0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/cstn_serializer.sv
// Per-half word latch and MSB-first slice shifter; an empty FIFO loads zeros.
module cstn_serializer
    import cstn_pkg::*;
#(
    parameter int BUS_W  = 8,
    parameter int WORD_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic              i_shift,
    input  logic              i_oe,
    input  logic [WORD_W-1:0] i_word,
    output logic [BUS_W-1:0]  o_data
);

    logic [WORD_W-1:0] r_sh;
    logic [WORD_W-1:0] w_word;

    assign w_word = i_valid ? i_word : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= w_word;
        end else if (i_shift) begin
            r_sh <= r_sh << BUS_W;
        end
    end

    // The first slice bypasses the latch so it is on the bus for the whole first beat.
    always_comb begin
        o_data = '0;
        if (i_load) begin
            o_data = w_word[WORD_W-1 -: BUS_W];
        end else if (i_oe) begin
            o_data = r_sh[WORD_W-1 -: BUS_W];
        end
    end

endmodule

// File: rtl/cstn_lcdc_gen.sv
// Passive-matrix panel timing controller: beat/line/frame sequencing, control
// strobes, AC-bias generation and FIFO-fed upper/lower data serialisation.
module cstn_lcdc_gen
    import cstn_pkg::*;
#(
    parameter int BUS_W     = 8,
    parameter int WORD_W    = 24,
    parameter int DUAL_SCAN = 1,
    parameter int H_FRONT   = 31,
    parameter int H_ACT     = 240,
    parameter int H_BACK    = 8,
    parameter int H_LP      = 6,
    parameter int H_WAIT    = 11,
    parameter int V_ACT     = 240,
    parameter int V_BACK    = 1,
    parameter int M_LINES   = 13
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            trig_mode,
    input  logic                            vsync_in,
    input  logic [WORD_W*(1+DUAL_SCAN)-1:0] fifo_data,
    input  logic                            fifo_empty,
    output logic                            fifo_re,
    output logic                            cstn_xck,
    output logic                            cstn_lp,
    output logic                            cstn_flm,
    output logic                            cstn_m,
    output logic                            cstn_dispoff,
    output logic [BUS_W-1:0]                cstn_ud,
    output logic [BUS_W-1:0]                cstn_ld,
    output logic                            underflow,
    input  logic                            underflow_clr,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int H_TOTAL = h_total(H_FRONT, H_ACT, H_BACK, H_LP, H_WAIT);
    localparam int LINES   = lines(V_ACT, V_BACK, DUAL_SCAN);
    localparam int BEATS   = beats(WORD_W, BUS_W);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(LINES + 1);
    localparam int BW      = $clog2(BEATS + 1);
    localparam int MW      = $clog2(M_LINES + 2);

    localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_WIN_LO = HW'(H_FRONT);
    localparam logic [HW-1:0] C_WIN_HI = HW'(H_FRONT + H_ACT);
    localparam logic [HW-1:0] C_LP_LO  = HW'(H_FRONT + H_ACT + H_BACK);
    localparam logic [HW-1:0] C_LP_HI  = HW'(H_FRONT + H_ACT + H_BACK + H_LP);
    localparam logic [VW-1:0] C_V_LAST = VW'(LINES - 1);
    localparam logic [VW-1:0] C_V_ACT  = VW'(LINES - V_BACK);
    localparam logic [BW-1:0] C_B_LAST = BW'(BEATS - 1);
    localparam logic [MW-1:0] C_M_LAST = MW'((M_LINES > 0) ? M_LINES - 1 : 0);

    if (!params_ok(BUS_W, WORD_W, DUAL_SCAN, H_ACT, H_LP, V_ACT)) begin : g_param_check
        $error("cstn_lcdc_gen: illegal parameter combination");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ph;
    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic [BW-1:0]   r_beat;
    logic [MW-1:0]   r_mcnt;
    logic            r_m;
    logic            r_uflow;
    logic            r_en;

    logic            w_run;
    logic            w_line_end;
    logic            w_frame_end;
    logic            w_active;
    logic            w_win;
    logic            w_load;
    logic            w_shift;
    logic            w_start;
    logic [BUS_W-1:0] w_ud;
    logic [BUS_W-1:0] w_ld;

    assign w_run       = (r_state == ST_RUN);
    assign w_line_end  = w_run & r_ph & (r_h == C_H_LAST);
    assign w_frame_end = w_line_end & (r_v == C_V_LAST);
    assign w_active    = (r_v < C_V_ACT);
    assign w_win       = w_run & w_active & (r_h >= C_WIN_LO) & (r_h < C_WIN_HI);
    assign w_load      = w_win & ~r_ph & (r_beat == '0);
    assign w_shift     = w_win & r_ph;
    assign w_start     = enable & (vsync_in | ~trig_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A running frame always completes; stop conditions are only sampled at its last clk.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_end && (trig_mode || !enable)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph   <= 1'b0;
            r_h    <= '0;
            r_v    <= '0;
            r_beat <= '0;
        end else if (!w_run) begin
            r_ph   <= 1'b0;
            r_h    <= '0;
            r_v    <= '0;
            r_beat <= '0;
        end else begin
            r_ph <= ~r_ph;
            if (r_ph) begin
                r_h <= (r_h == C_H_LAST) ? '0 : r_h + 1'b1;
            end
            if (w_line_end) begin
                r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
            end
            if (w_shift) begin
                r_beat <= (r_beat == C_B_LAST) ? '0 : r_beat + 1'b1;
            end
        end
    end

    // The M line counter spans frames so the AC-bias pattern is not reset each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcnt <= '0;
            r_m    <= 1'b0;
        end else if (w_line_end) begin
            if (M_LINES == 0) begin
                if (w_frame_end) r_m <= ~r_m;
            end else if (r_mcnt == C_M_LAST) begin
                r_mcnt <= '0;
                r_m    <= ~r_m;
            end else begin
                r_mcnt <= r_mcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uflow <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_en <= enable;
            if (underflow_clr) begin
                r_uflow <= 1'b0;
            end else if (w_load && fifo_empty) begin
                r_uflow <= 1'b1;
            end
        end
    end

    cstn_serializer #(
        .BUS_W  (BUS_W),
        .WORD_W (WORD_W)
    ) u_ser_up (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_valid (~fifo_empty),
        .i_shift (w_shift),
        .i_oe    (w_win),
        .i_word  (fifo_data[WORD_W*(1+DUAL_SCAN)-1 -: WORD_W]),
        .o_data  (w_ud)
    );

    if (DUAL_SCAN != 0) begin : g_lower
        cstn_serializer #(
            .BUS_W  (BUS_W),
            .WORD_W (WORD_W)
        ) u_ser_lo (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_load  (w_load),
            .i_valid (~fifo_empty),
            .i_shift (w_shift),
            .i_oe    (w_win),
            .i_word  (fifo_data[WORD_W-1:0]),
            .o_data  (w_ld)
        );
    end else begin : g_no_lower
        assign w_ld = '0;
    end

    assign fifo_re      = w_load & ~fifo_empty;
    assign cstn_xck     = w_shift;
    assign cstn_lp      = w_run & (r_h >= C_LP_LO) & (r_h < C_LP_HI);
    assign cstn_flm     = w_run & (r_v == '0);
    assign cstn_m       = r_m;
    assign cstn_dispoff = r_en & ~(~w_run & ~enable);
    assign cstn_ud      = w_ud;
    assign cstn_ld      = w_ld;
    assign underflow    = r_uflow;
    assign frame_done   = w_frame_end;
    assign busy         = w_run;

endmodule

// File: tb/tb_cstn_lcdc_gen.sv
// Scoreboard bench: a dual-scan 8-bit instance and a single-scan 4-bit instance with M_LINES=2.
module tb_cstn_lcdc_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic trig_mode = 1'b0;
    logic vsync_in = 1'b0;
    logic underflow_clr = 1'b0;

    always #5 clk = ~clk;

    logic [47:0] a_fd;
    logic        a_empty = 1'b0;
    logic        a_re, a_xck, a_lp, a_flm, a_m, a_doff, a_uf, a_fdone, a_busy;
    logic [7:0]  a_ud, a_ld;
    logic [23:0] b_fd;
    logic        b_empty = 1'b0;
    logic        b_re, b_xck, b_lp, b_flm, b_m, b_doff, b_uf, b_fdone, b_busy;
    logic [3:0]  b_ud, b_ld;

    int unsigned a_rd, b_rd;
    assign a_fd = a_rd[0] ? 48'hDDEEFF_445566 : 48'hAABBCC_112233;
    assign b_fd = b_rd[0] ? 24'h9ABCDE : 24'h123456;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd <= 0;
            b_rd <= 0;
        end else begin
            if (a_re) a_rd <= a_rd + 1;
            if (b_re) b_rd <= b_rd + 1;
        end
    end

    cstn_lcdc_gen #(
        .BUS_W(8), .WORD_W(24), .DUAL_SCAN(1), .H_FRONT(2), .H_ACT(6), .H_BACK(1),
        .H_LP(2), .H_WAIT(1), .V_ACT(4), .V_BACK(1), .M_LINES(0)
    ) u_a (
        .clk(clk), .rst(rst), .enable(enable), .trig_mode(trig_mode), .vsync_in(vsync_in),
        .fifo_data(a_fd), .fifo_empty(a_empty), .fifo_re(a_re), .cstn_xck(a_xck),
        .cstn_lp(a_lp), .cstn_flm(a_flm), .cstn_m(a_m), .cstn_dispoff(a_doff),
        .cstn_ud(a_ud), .cstn_ld(a_ld), .underflow(a_uf), .underflow_clr(underflow_clr),
        .frame_done(a_fdone), .busy(a_busy)
    );

    cstn_lcdc_gen #(
        .BUS_W(4), .WORD_W(24), .DUAL_SCAN(0), .H_FRONT(2), .H_ACT(6), .H_BACK(1),
        .H_LP(2), .H_WAIT(1), .V_ACT(4), .V_BACK(1), .M_LINES(2)
    ) u_b (
        .clk(clk), .rst(rst), .enable(enable), .trig_mode(trig_mode), .vsync_in(vsync_in),
        .fifo_data(b_fd), .fifo_empty(b_empty), .fifo_re(b_re), .cstn_xck(b_xck),
        .cstn_lp(b_lp), .cstn_flm(b_flm), .cstn_m(b_m), .cstn_dispoff(b_doff),
        .cstn_ud(b_ud), .cstn_ld(b_ld), .underflow(b_uf), .underflow_clr(underflow_clr),
        .frame_done(b_fdone), .busy(b_busy)
    );

    int n_total = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor A: dual-scan 8-bit, 3 beats/word, 3 lines/frame (2 active), M per frame.
    logic [15:0] a_q[$];
    logic [15:0] a_e;
    logic [47:0] a_rword;
    logic [23:0] a_u, a_l;
    logic        a_rflag, a_pempty, a_lpp;
    int          a_xk, a_line, a_rdl, a_miss, a_sx, a_lpw, a_t, a_lpt, a_frames;

    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            a_rflag = 0; a_pempty = 0; a_lpp = 0;
            a_xk = 0; a_line = 0; a_rdl = 0; a_miss = 0; a_sx = 0; a_lpw = 0;
            a_t = 0; a_lpt = -1; a_frames = 0;
        end else begin
            a_t++;
            if (!a_busy) begin
                a_line = 0; a_lpt = -1; a_xk = 0; a_rdl = 0; a_miss = 0;
            end
            if (a_re) begin
                a_rflag = 1;
                a_rword = a_fd;
            end
            if (a_xck) begin
                if (a_xk % 3 == 0) begin
                    check_eq("a_read_vs_empty", a_rflag, !a_pempty);
                    a_u = a_rflag ? a_rword[47:24] : 24'h0;
                    a_l = a_rflag ? a_rword[23:0] : 24'h0;
                    for (int k = 0; k < 3; k++) begin
                        a_q.push_back({a_u[23:16], a_l[23:16]});
                        a_u = a_u << 8;
                        a_l = a_l << 8;
                    end
                    if (a_rflag) a_rdl++; else a_miss++;
                    a_rflag = 0;
                end
                if (a_q.size() == 0) begin
                    check_eq("a_sb_underrun", 1, 0);
                end else begin
                    a_e = a_q.pop_front();
                    check_eq("a_data", {a_ud, a_ld}, a_e);
                end
                a_xk++;
                a_sx = 0;
            end else begin
                a_sx++;
            end
            if (a_lp && !a_lpp) begin
                check_eq("a_xck_per_line", a_xk, (a_line < 2) ? 6 : 0);
                check_eq("a_words_per_line", a_rdl + a_miss, (a_line < 2) ? 2 : 0);
                check_eq("a_flm", a_flm, (a_line == 0));
                check_eq("a_m", a_m, a_frames % 2);
                if (a_line < 2) check_eq("a_lp_offset", a_sx, 3);
                if (a_lpt >= 0) check_eq("a_line_period", a_t - a_lpt, 24);
                a_lpt = a_t;
                a_line++;
                a_xk = 0; a_rdl = 0; a_miss = 0; a_lpw = 0;
            end
            if (a_lp) a_lpw++;
            if (!a_lp && a_lpp) check_eq("a_lp_width", a_lpw, 4);
            a_lpp = a_lp;
            if (a_fdone) begin
                check_eq("a_lines_per_frame", a_line, 3);
                a_line = 0;
                a_frames++;
            end
            a_pempty = a_empty;
        end
    end

    // Monitor B: single-scan 4-bit, 6 nibbles/word, 5 lines/frame (4 active), M every 2 lines.
    logic [3:0]  b_q[$];
    logic [3:0]  b_e;
    logic [23:0] b_rword, b_u;
    logic        b_rflag, b_pempty, b_lpp;
    int          b_xk, b_line, b_words, b_gline, b_frames;

    always @(negedge clk) begin
        if (rst) begin
            b_q.delete();
            b_rflag = 0; b_pempty = 0; b_lpp = 0;
            b_xk = 0; b_line = 0; b_words = 0; b_gline = 0; b_frames = 0;
        end else begin
            if (!b_busy) begin
                b_line = 0; b_xk = 0; b_words = 0;
            end
            if (b_re) begin
                b_rflag = 1;
                b_rword = b_fd;
            end
            if (b_xck) begin
                if (b_xk % 6 == 0) begin
                    check_eq("b_read_vs_empty", b_rflag, !b_pempty);
                    b_u = b_rflag ? b_rword : 24'h0;
                    for (int k = 0; k < 6; k++) begin
                        b_q.push_back(b_u[23:20]);
                        b_u = b_u << 4;
                    end
                    b_words++;
                    b_rflag = 0;
                end
                if (b_q.size() == 0) begin
                    check_eq("b_sb_underrun", 1, 0);
                end else begin
                    b_e = b_q.pop_front();
                    check_eq("b_data", b_ud, b_e);
                end
                check_eq("b_ld_zero", b_ld, 0);
                b_xk++;
            end
            if (b_lp && !b_lpp) begin
                check_eq("b_xck_per_line", b_xk, (b_line < 4) ? 6 : 0);
                check_eq("b_words_per_line", b_words, (b_line < 4) ? 1 : 0);
                check_eq("b_flm", b_flm, (b_line == 0));
                check_eq("b_m", b_m, (b_gline / 2) % 2);
                b_line++;
                b_gline++;
                b_xk = 0; b_words = 0;
            end
            b_lpp = b_lp;
            if (b_fdone) begin
                check_eq("b_lines_per_frame", b_line, 5);
                b_line = 0;
                b_frames++;
            end
            b_pempty = b_empty;
        end
    end

    task automatic wait_a_fdone(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_fdone) break;
        end
        check_eq(tag, a_fdone, 1);
    endtask

    task automatic wait_a_re(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_re) break;
        end
        check_eq(tag, a_re, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (a_busy || b_busy); i++) @(negedge clk);
        check_eq(tag, {a_busy, b_busy}, 2'b00);
    endtask

    task automatic count_xck(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_xck || b_xck || a_busy || b_busy) cnt++;
        end
        check_eq(tag, cnt, 0);
    endtask

    int n_a, n_b;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("a_reset_outputs", {a_re, a_xck, a_lp, a_flm, a_m, a_doff, a_ud, a_ld, a_uf, a_fdone, a_busy}, 0);
        check_eq("b_reset_outputs", {b_re, b_xck, b_lp, b_flm, b_m, b_doff, b_ud, b_ld, b_uf, b_fdone, b_busy}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Free-running frames.
        enable = 1'b1;
        trig_mode = 1'b0;
        wait_a_fdone("a_frame1_timeout", 200);
        wait_a_fdone("a_frame2_timeout", 200);
        check_eq("a_dispoff_on", a_doff, 1);
        check_eq("a_busy_run", a_busy, 1);

        // Second word of line 0 meets an empty FIFO.
        wait_a_fdone("a_frame3_timeout", 200);
        wait_a_re("a_first_read_timeout", 50);
        @(posedge clk); #1 a_empty = 1'b1;
        repeat (10) @(posedge clk);
        #1 a_empty = 1'b0;
        check_eq("a_uflow_set", a_uf, 1);
        repeat (40) @(posedge clk);
        #1 check_eq("a_uflow_sticky", a_uf, 1);
        underflow_clr = 1'b1;
        @(posedge clk);
        #1 underflow_clr = 1'b0;
        check_eq("a_uflow_clr", a_uf, 0);
        check_eq("b_uflow_none", b_uf, 0);

        // Clear and set in the same clk: clear wins.
        wait_a_fdone("a_frame4_timeout", 200);
        wait_a_re("a_first_read2_timeout", 50);
        @(posedge clk); #1 a_empty = 1'b1;
        repeat (5) @(posedge clk);
        #1 underflow_clr = 1'b1;
        @(posedge clk);
        #1 underflow_clr = 1'b0;
        check_eq("a_uflow_collide", a_uf, 0);
        repeat (4) @(posedge clk);
        #1 a_empty = 1'b0;

        // Trigger mode: idle until vsync, then exactly one frame.
        trig_mode = 1'b1;
        wait_idle("trig_stop_timeout", 400);
        count_xck("trig_idle_quiet", 30);
        n_a = a_frames;
        n_b = b_frames;
        @(posedge clk);
        #1 vsync_in = 1'b1;
        @(posedge clk);
        #1 vsync_in = 1'b0;
        check_eq("a_busy_on_vsync", a_busy, 1);
        wait_idle("trig_frame_timeout", 400);
        check_eq("a_one_frame", a_frames - n_a, 1);
        check_eq("b_one_frame", b_frames - n_b, 1);
        count_xck("trig_after_quiet", 40);

        // Enable dropped mid-frame: frame completes, then IDLE with display off.
        @(posedge clk);
        #1 trig_mode = 1'b0;
        n_a = a_frames;
        n_b = b_frames;
        repeat (30) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle("disable_timeout", 400);
        check_eq("a_disable_frame", a_frames - n_a, 1);
        check_eq("b_disable_frame", b_frames - n_b, 1);
        check_eq("a_dispoff_off", a_doff, 0);
        check_eq("b_dispoff_off", b_doff, 0);

        // Reset asserted mid-line of a new frame.
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (30) @(posedge clk);
        check_eq("a_busy_before_rst", a_busy, 1);
        #3 rst = 1'b1;
        #1;
        check_eq("a_async_reset", {a_re, a_xck, a_lp, a_flm, a_m, a_doff, a_ud, a_ld, a_uf, a_fdone, a_busy}, 0);
        check_eq("b_async_reset", {b_re, b_xck, b_lp, b_flm, b_m, b_doff, b_ud, b_ld, b_uf, b_fdone, b_busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
